// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file types for the writeback path.
//   rvga_reg     : 5-bit architectural register index
//   rvga_word    : 32-bit data word
//   rvga_wb_req  : one register-file write request {rd, data}
//   rvga_reg_onehot : one-hot decode of a register index
package wb_port_arbiter_pkg;

   localparam int RVGA_NUM_REGS = 32;

   typedef logic [4:0]  rvga_reg;
   typedef logic [31:0] rvga_word;

   typedef struct packed {
      rvga_reg  rd;
      rvga_word data;
   } rvga_wb_req;

   function automatic logic [RVGA_NUM_REGS-1:0] rvga_reg_onehot(input rvga_reg r);
      logic [RVGA_NUM_REGS-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO for long-latency writeback results.
//   clk, rst         : clock, synchronous active-high reset
//   push, push_el    : enqueue request (ignored when full)
//   pop              : dequeue request (ignored when empty)
//   head             : oldest entry, read combinationally from storage
//   full, empty      : occupancy flags
//   entries, valid   : raw storage plus per-slot occupancy, for hazard logic
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int  depth_p = 4,
   parameter type el_t    = rvga_wb_req
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  el_t                push_el,
   input  logic               pop,
   output el_t                head,
   output logic               full,
   output logic               empty,
   output el_t                entries [depth_p],
   output logic [depth_p-1:0] valid
);

   localparam int ptr_w = $clog2(depth_p);
   localparam int cnt_w = ptr_w + 1;

   el_t              mem [depth_p];
   logic [ptr_w-1:0] rd_ptr;
   logic [ptr_w-1:0] wr_ptr;
   logic [cnt_w-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == cnt_w'(depth_p));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];
   assign entries = mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + cnt_w'(do_push) - cnt_w'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_el;
   end

   // A slot is occupied when its distance from the read pointer (modulo
   // depth) is below the count; this covers the full case where pointers meet.
   for (genvar i = 0; i < depth_p; i++) begin : g_valid
      logic [ptr_w-1:0] off;
      assign off      = ptr_w'(i) - rd_ptr;
      assign valid[i] = ({1'b0, off} < count);
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// writeback path and buffered long-latency results.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   pipe_v_i/rd_i/data_i  : pipeline writeback request
//   lu_v_i/rd_i/data_i    : long-latency result, accepted when lu_ready_o
//   lu_ready_o            : result FIFO not full
//   stall_v_o             : pipeline request not accepted this cycle
//   rd_o, rd_data_o, rd_w_v_o : registered register-file write port
//   pending_mask_o        : registers targeted by buffered results
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int depth_p  = 4,
   parameter int starve_p = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     pipe_v_i,
   input  rvga_reg                  pipe_rd_i,
   input  rvga_word                 pipe_data_i,
   input  logic                     lu_v_i,
   input  rvga_reg                  lu_rd_i,
   input  rvga_word                 lu_data_i,
   output logic                     lu_ready_o,
   output logic                     stall_v_o,
   output rvga_reg                  rd_o,
   output rvga_word                 rd_data_o,
   output logic                     rd_w_v_o,
   output logic [RVGA_NUM_REGS-1:0] pending_mask_o
);

   rvga_wb_req         head;
   rvga_wb_req         entries [depth_p];
   logic [depth_p-1:0] valid;
   logic               full;
   logic               empty;
   logic               sel_fifo;
   logic               sel_pipe;
   logic               waw_match;
   logic               starve_hit;
   logic [3:0]         starve_cnt;
   rvga_wb_req         lu_el;

   assign lu_el = '{rd: lu_rd_i, data: lu_data_i};

   wb_result_fifo #(
      .depth_p (depth_p),
      .el_t    (rvga_wb_req)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .push    (lu_v_i),
      .push_el (lu_el),
      .pop     (sel_fifo),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .entries (entries),
      .valid   (valid)
   );

   always_comb begin
      waw_match      = 1'b0;
      pending_mask_o = '0;
      for (int i = 0; i < depth_p; i++) begin
         if (valid[i]) begin
            pending_mask_o = pending_mask_o | rvga_reg_onehot(entries[i].rd);
            if (entries[i].rd == pipe_rd_i) waw_match = 1'b1;
         end
      end
      pending_mask_o[0] = 1'b0;
   end

   assign starve_hit = (starve_cnt == 4'(starve_p));
   assign sel_fifo   = !empty && (!pipe_v_i || starve_hit || waw_match);
   assign sel_pipe   = pipe_v_i && !sel_fifo;
   assign stall_v_o  = pipe_v_i && sel_fifo;
   assign lu_ready_o = !full;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (empty || sel_fifo) begin
         starve_cnt <= '0;
      end else if (!starve_hit) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // x0 writes still consume their grant but never raise the write enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_o      <= '0;
         rd_data_o <= '0;
         rd_w_v_o  <= 1'b0;
      end else if (sel_fifo) begin
         rd_o      <= head.rd;
         rd_data_o <= head.data;
         rd_w_v_o  <= (head.rd != '0);
      end else if (sel_pipe) begin
         rd_o      <= pipe_rd_i;
         rd_data_o <= pipe_data_i;
         rd_w_v_o  <= (pipe_rd_i != '0);
      end else begin
         rd_w_v_o  <= 1'b0;
      end
   end

endmodule
